// File: rtl/packet_egress_router.sv
// Egress router: FIFO-buffered merged stream, steered to one of four
// valid/ready output ports by the destination ID in the packet's top bits.
module packet_egress_router #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] pkt_count,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dest;
    logic             push, pop, xfer;

    assign dest      = data_q[WIDTH-1 -: 2];
    assign out_valid = (state_q == S_HOLD) ? (4'b0001 << dest) : 4'b0000;
    assign out_data  = data_q;
    assign pkt_count = cnt_q;
    assign in_ready  = (occ_q != OW'(DEPTH));
    assign busy      = (occ_q != '0) || (state_q == S_HOLD);

    // Only the held destination's ready matters; others are masked by out_valid.
    assign xfer = |(out_valid & out_ready);
    assign push = in_valid && in_ready;
    assign pop  = (occ_q != '0) && ((state_q == S_EMPTY) || xfer);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q + OW'(push) - OW'(pop);
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d  = rptr_q + AW'(1);
            data_d  = mem_q[rptr_q];
            state_d = S_HOLD;
        end else if (xfer) begin
            state_d = S_EMPTY;
        end
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            if (push) begin
                mem_q[wptr_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_packet_egress_router.sv
// Directed testbench for packet_egress_router (4-bit counter to see the wrap).
module tb_packet_egress_router;
    localparam int WIDTH = 34;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] pkt_count;
    logic             busy;

    int errors = 0;
    int checks = 0;

    packet_egress_router #(.WIDTH(WIDTH), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .pkt_count(pkt_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] mk(input int d, input int p);
        logic [1:0] dd;
        dd = 2'(d);
        return {dd, 32'(p)};
    endfunction

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_pkt;
    int acc, pushes, pops, seq, delivered, guard;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'h0;
        #3;
        chk("rst_out_valid", out_valid, 4'h0);
        chk("rst_out_data", out_data, '0);
        chk("rst_count", pkt_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single packet, offered so it is accepted on the first edge after release
        rst_n     = 1'b1;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = mk(2, 32'hAA);
        tick();
        in_valid = 1'b0;
        chk("single_lat0", out_valid, 4'h0);
        tick();
        chk("single_valid", out_valid, 4'b0100);
        chk("single_data", out_data, mk(2, 32'hAA));
        chk("single_busy1", busy, 1);
        tick();
        chk("single_count", pkt_count, 1);
        chk("single_busy0", busy, 0);
        chk("single_done", out_valid, 4'h0);

        // Fill and stall
        out_ready = 4'h0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = mk(i % 4, 32'h100 + i);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_in_ready", in_ready, 0);
        out_ready = 4'hF;
        for (int j = 0; j < 5; j++) begin
            exp_pkt = mk(j % 4, 32'h100 + j);
            chk("drain_data", out_data, exp_pkt);
            chk("drain_valid", out_valid, 4'b0001 << (j % 4));
            tick();
        end
        chk("drain_in_ready", in_ready, 1);
        chk("drain_busy", busy, 0);
        chk("drain_count", pkt_count, 6);

        // Head-of-line blocking
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        in_data   = mk(1, 32'hA1);
        tick();
        in_data = mk(3, 32'hB3);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hol_valid", out_valid, 4'b0010);
            chk("hol_data", out_data, mk(1, 32'hA1));
            tick();
        end
        chk("hol_count", pkt_count, 6);
        out_ready = 4'b1010;
        tick();
        chk("hol_next_valid", out_valid, 4'b1000);
        chk("hol_next_data", out_data, mk(3, 32'hB3));
        chk("hol_count1", pkt_count, 7);
        tick();
        chk("hol_count2", pkt_count, 8);
        chk("hol_empty", out_valid, 4'h0);

        // Simultaneous push/pop around a full router
        out_ready = 4'h0;
        in_valid  = 1'b1;
        seq = 0;
        guard = 0;
        in_data = mk(seq, 32'hC000 + seq);
        while (in_ready && guard < 10) begin
            q.push_back(in_data);
            seq++;
            tick();
            in_data = mk(seq, 32'hC000 + seq);
            guard++;
        end
        chk("full_fill", q.size(), 5);
        out_ready = 4'hF;
        pushes = 0;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (|(out_valid & out_ready)) begin
                exp_pkt = (q.size() > 0) ? q.pop_front() : '0;
                chk("pp_order", out_data, exp_pkt);
                pops++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                pushes++;
                seq++;
            end
            tick();
            in_data = mk(seq, 32'hC000 + seq);
        end
        chk("pp_pops", pops, 10);
        chk("pp_pushes", pushes, 9);
        chk("pp_occ_in_ready", in_ready, 1);
        in_valid = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            if (|(out_valid & out_ready)) begin
                exp_pkt = q.pop_front();
                chk("pp_drain", out_data, exp_pkt);
            end
            tick();
            guard++;
        end
        chk("pp_drain_left", q.size(), 0);
        chk("pp_busy", busy, 0);
        chk("pp_count", pkt_count, 4'((8 + 14) % 16));

        // Async reset with 3 packets inside
        out_ready = 4'h0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = mk(i, 32'hD00 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("ar_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 4'h0);
        chk("ar_count", pkt_count, 0);
        chk("ar_data", out_data, '0);
        chk("ar_busy", busy, 0);
        chk("ar_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        out_ready = 4'hF;
        tick();
        tick();
        tick();
        chk("ar_stale_valid", out_valid, 4'h0);
        chk("ar_stale_count", pkt_count, 0);

        // Counter wrap over 17 deliveries
        seq = 0;
        delivered = 0;
        in_valid = 1'b1;
        in_data = mk(0, 32'hE00);
        for (int c = 0; c < 40 && delivered < 17; c++) begin
            logic did;
            did = |(out_valid & out_ready);
            if (in_valid && in_ready) seq++;
            tick();
            if (seq >= 17) in_valid = 1'b0;
            in_data = mk(seq, 32'hE00 + seq);
            if (did) begin
                delivered++;
                if (delivered == 15) chk("wrap_15", pkt_count, 15);
                if (delivered == 16) chk("wrap_16", pkt_count, 0);
            end
        end
        chk("wrap_delivered", delivered, 17);
        chk("wrap_17", pkt_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
